booth_operand_sequencer: RTL and testbench

Upstream feeder for the 8-bit Booth multiplier core.
- Accepts operand pairs (multiplicand, multiplier) over a valid/ready stream and buffers them in a small FIFO.
- Drives the core's shared 8-bit operand bus and start strobe in the core's load order, then waits for done.
- Captures the 16-bit product into a valid/ready result register, so the core can be used back-to-back without software handshaking.

---
 rtl/booth_seq_pkg.sv | 29 ++
 rtl/booth_op_fifo.sv | 70 +++++++
 rtl/booth_operand_sequencer.sv | 170 +++++++++++++++++
 tb/tb_booth_operand_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_pkg
// Description : Shared types and widths for the Booth operand sequencer:
//               operand/product widths, sequencer FSM state encoding and the
//               operand-pair record carried through the input FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_seq_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Explicitly encoded so the state values stay fixed across tool versions
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_M = 3'd1,
        ST_LOAD_Q = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] mcand;
        logic [OP_W-1:0] mplier;
    } op_pair_t;

endpackage
`default_nettype wire

// File: rtl/booth_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : booth_op_fifo
// Description : Synchronous FIFO of operand pairs. DEPTH must be a power of
//               two (>=2) so the pointers wrap naturally. Push while full and
//               pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_op_fifo
    import booth_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  op_pair_t               din,
    input  logic                   pop,
    output op_pair_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

    // Storage is not reset: contents are only observed behind a valid count
    op_pair_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            do_push, do_pop;

    // Qualify requests and compute next pointers / occupancy
    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop  && (count_q != '0);
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/booth_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : booth_operand_sequencer
// Description : Feeds operand pairs from a FIFO into an 8-bit Booth multiplier
//               core over its shared operand bus (multiplicand with start
//               strobe, then multiplier), waits for done with a timeout, and
//               parks the product in a single valid/ready result slot.
//               Optional build macro: SEQ_ZERO_BYPASS_EN - pairs with a zero
//               operand skip the core and produce a zero result directly.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_operand_sequencer
    import booth_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_mcand,
    input  logic [OP_W-1:0]   in_mplier,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_product,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] res_data,
    output logic              busy,
    output logic              err_timeout
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    op_pair_t                 fifo_din, fifo_head;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;

    state_t                   state_q, state_d;
    logic [OP_W-1:0]          op_b_q, op_b_d;
    logic                     mul_start_q, mul_start_d;
    logic [OP_W-1:0]          mul_a_q, mul_a_d;
    logic                     res_valid_q, res_valid_d;
    logic [PROD_W-1:0]        res_data_q, res_data_d;
    logic                     err_timeout_q, err_timeout_d;
    logic [TW-1:0]            tmr_q, tmr_d;

    assign fifo_din  = '{mcand: in_mcand, mplier: in_mplier};
    assign fifo_push = in_valid && !fifo_full;

    booth_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequencer next-state logic; every output is precomputed for the next cycle
    always_comb begin
        state_d       = state_q;
        op_b_d        = op_b_q;
        mul_start_d   = 1'b0;
        mul_a_d       = mul_a_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        err_timeout_d = err_timeout_q;
        tmr_d         = tmr_q;
        fifo_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Single result slot: never issue while a result is pending
                if (!fifo_empty && !res_valid_q) begin
                    fifo_pop = 1'b1;
                    // The multiplicand goes straight to the bus register; only
                    // the multiplier needs to be remembered for the next cycle
                    op_b_d   = fifo_head.mplier;
`ifdef SEQ_ZERO_BYPASS_EN
                    if (fifo_head.mcand == '0 || fifo_head.mplier == '0) begin
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end else begin
                        mul_start_d = 1'b1;
                        mul_a_d     = fifo_head.mcand;
                        state_d     = ST_LOAD_M;
                    end
`else
                    mul_start_d = 1'b1;
                    mul_a_d     = fifo_head.mcand;
                    state_d     = ST_LOAD_M;
`endif
                end
            end
            ST_LOAD_M: begin
                mul_a_d = op_b_q;
                state_d = ST_LOAD_Q;
            end
            ST_LOAD_Q: begin
                tmr_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    res_data_d  = mul_product;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (tmr_q == TMR_LAST) begin
                    // Abandon the pair; the flag stays set until reset
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_b_q        <= '0;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            err_timeout_q <= 1'b0;
            tmr_q         <= '0;
        end else begin
            state_q       <= state_d;
            op_b_q        <= op_b_d;
            mul_start_q   <= mul_start_d;
            mul_a_q       <= mul_a_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            err_timeout_q <= err_timeout_d;
            tmr_q         <= tmr_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign mul_start   = mul_start_q;
    assign mul_a       = mul_a_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_booth_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_booth_operand_sequencer
// Description : Scoreboard bench: a behavioural Booth core answers the
//               operand bus, a monitor checks every result handshake against
//               signed products computed from the pushed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_operand_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_mcand = '0;
    logic [7:0]  in_mplier = '0;
    logic        mul_done = 1'b0;
    logic [15:0] mul_product = '0;
    logic        res_ready = 1'b0;
    wire         in_ready, mul_start, res_valid, busy, err_timeout;
    wire [7:0]   mul_a;
    wire [15:0]  res_data;

    booth_operand_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mcand(in_mcand), .in_mplier(in_mplier), .mul_start(mul_start),
        .mul_a(mul_a), .mul_done(mul_done), .mul_product(mul_product),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_prod [$];   // expected results, in order
    logic [15:0] exp_ops  [$];   // expected {mcand, mplier} bus sequence
    int          core_lat = 2;
    bit          core_hang = 1'b0;
    bit          rand_ready = 1'b0;
    int          start_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // Behavioural core: strobe+multiplicand, then multiplier, done after core_lat
    int          c_phase = 0;
    int          c_cnt = 0;
    bit          c_hang = 1'b0;
    logic [7:0]  c_a = '0;
    logic [7:0]  c_exp_b = '0;
    logic [15:0] c_e = '0;
    always begin
        @(negedge clk); #1;
        if (!rst_n) begin
            c_phase  = 0;
            mul_done = 1'b0;
        end else begin
            case (c_phase)
                0: if (mul_start) begin
                    mul_done = 1'b0;
                    c_a      = mul_a;
                    c_hang   = core_hang;
                    start_cnt++;
                    if (exp_ops.size() == 0) begin
                        chk("start_unexpected", mul_start, 1'b0);
                        c_exp_b = '0;
                    end else begin
                        c_e     = exp_ops.pop_front();
                        c_exp_b = c_e[7:0];
                        chk("bus_mcand", mul_a, c_e[15:8]);
                    end
                    c_phase = 1;
                end
                1: begin
                    chk("start_one_cycle", mul_start, 1'b0);
                    chk("bus_mplier", mul_a, c_exp_b);
                    mul_product = ref_prod(c_a, mul_a);
                    if (c_hang) c_phase = 0;
                    else if (core_lat == 0) begin mul_done = 1'b1; c_phase = 0; end
                    else begin c_cnt = core_lat; c_phase = 2; end
                end
                default: begin
                    c_cnt--;
                    if (c_cnt <= 0) begin mul_done = 1'b1; c_phase = 0; end
                end
            endcase
        end
    end

    // Result monitor / scoreboard
    logic        pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    always begin
        @(negedge clk); #1;
        if (rst_n) begin
            if (pv && !pr) begin
                chk("hold_valid", res_valid, 1'b1);
                chk("hold_data", res_data, pd);
            end
            if (res_valid) chk("no_issue_while_valid", mul_start, 1'b0);
            if (res_valid && res_ready) begin
                if (exp_prod.size() == 0) chk("unexpected_result", res_valid, 1'b0);
                else chk("result", res_data, exp_prod.pop_front());
            end
        end
        pv = res_valid && rst_n;
        pr = res_ready;
        pd = res_data;
    end

    // Random consumer back-pressure
    always @(negedge clk) if (rand_ready) res_ready = 1'($urandom_range(0, 1));

    task automatic push(input logic [7:0] a, input logic [7:0] b, input bit want);
        int n = 0;
        in_mcand = a; in_mplier = b; in_valid = 1'b1;
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        if (!in_ready) chk("push_timeout", in_ready, 1'b1);
        else begin
            exp_ops.push_back({a, b});
            if (want) exp_prod.push_back(ref_prod(a, b));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_prod.size() != 0 || busy || res_valid) && n < 2000) begin @(negedge clk); n++; end
        chk("drain_pending", exp_prod.size(), 0);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!mul_start && n < 50) begin @(negedge clk); n++; end
        chk("start_seen", mul_start, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_mul_start"}, mul_start, 1'b0);
        chk({tag, "_mul_a"}, mul_a, 8'h00);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_data"}, res_data, 16'h0000);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err_timeout, 1'b0);
    endtask

    initial begin
        int n, s0;
        logic [7:0] ra, rb;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 5 x 3: issue latency and bus order
        core_lat = 3;
        push(8'h05, 8'h03, 1'b1);
        chk("lat_n1_start", mul_start, 1'b0);
        @(negedge clk);
        chk("lat_n2_start", mul_start, 1'b1);
        chk("lat_bus_m", mul_a, 8'h05);
        @(negedge clk);
        chk("lat_bus_q", mul_a, 8'h03);
        drain();

        // signed corner products
        push(8'hFC, 8'h07, 1'b1);
        push(8'h80, 8'h80, 1'b1);
        drain();

        // FIFO fill with stalled core: 4 queued + 1 in flight
        core_lat = 30;
        for (int i = 0; i < 5; i++) push(8'($urandom), 8'($urandom), 1'b1);
        chk("full_after_5", in_ready, 1'b0);
        chk("busy_when_full", busy, 1'b1);
        push(8'($urandom), 8'($urandom), 1'b1);
        drain();

        // consumer stall: result held, nothing issued
        core_lat = 2;
        res_ready = 1'b0;
        push(8'h02, 8'h07, 1'b1);
        push(8'h03, 8'h03, 1'b1);
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        chk("stall_valid", res_valid, 1'b1);
        chk("stall_no_start", start_cnt - s0, 0);
        res_ready = 1'b1;
        drain();

        // timeout: core never answers
        core_hang = 1'b1;
        push(8'h03, 8'h04, 1'b0);
        wait_start(n);
        @(negedge clk);
        core_hang = 1'b0;
        n = 1;
        while (!err_timeout && n < 200) begin @(negedge clk); n++; end
        chk("timeout_cycles", n, TIMEOUT + 2);
        chk("timeout_idle", busy, 1'b0);
        push(8'h06, 8'h07, 1'b1);
        drain();
        chk("err_sticky", err_timeout, 1'b1);

        // randomized traffic with random back-pressure and core latency
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            core_lat = $urandom_range(0, 6);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 8'h80;
            if ($urandom_range(0, 7) == 0) rb = 8'hFF;
            push(ra, rb, 1'b1);
        end
        rand_ready = 1'b0;
        @(negedge clk);
        res_ready = 1'b1;
        drain();

        // reset while waiting on the core
        core_lat = 20;
        push(8'h09, 8'h09, 1'b1);
        wait_start(n);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        exp_prod.delete();
        exp_ops.delete();
        rst_n = 1'b1;
        @(negedge clk);
        core_lat = 1;
        push(8'h02, 8'h02, 1'b1);
        drain();

        // zero operand
        s0 = start_cnt;
        push(8'h00, 8'h09, 1'b1);
        drain();
`ifdef SEQ_ZERO_BYPASS_EN
        chk("zero_bypass_no_start", start_cnt - s0, 0);
`else
        chk("zero_through_core", start_cnt - s0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
